// File: rtl/unsigned_iter_divider_16by8_pkg.sv
// Shared types and constants for the iterative restoring divider.
package unsigned_iter_divider_16by8_pkg;

    localparam int unsigned DwDefault = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/unsigned_iter_divider_16by8_if.sv
// Operand/result valid-ready bundle between a requester and the divider.
interface unsigned_iter_divider_16by8_if
    import unsigned_iter_divider_16by8_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) ();

    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            div_zero;
    logic            overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

endinterface

// File: rtl/unsigned_iter_divider_16by8_div_restoring_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module unsigned_iter_divider_16by8_div_restoring_step
    import unsigned_iter_divider_16by8_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input  logic [DW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] divisor_i,
    output logic [DW-1:0] rem_o,
    output logic          q_o
);

    logic [DW:0]   shifted;
    logic [DW+1:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = {1'b0, shifted} - {2'b00, divisor_i};

    // rem_i < divisor keeps any non-negative difference below 2^DW, so bit DW is zero then.
    assign q_o   = ~|diff[DW+1:DW];
    assign rem_o = q_o ? diff[DW-1:0] : shifted[DW-1:0];

endmodule

// File: rtl/unsigned_iter_divider_16by8.sv
// Sequential 2*DW / DW restoring divider with valid/ready handshakes, one job in flight.
module unsigned_iter_divider_16by8
    import unsigned_iter_divider_16by8_pkg::*;
#(
    parameter int unsigned DW = DwDefault
) (
    input logic                          clk,
    input logic                          rst,
    unsigned_iter_divider_16by8_if.slave bus
);

    localparam int unsigned CW = cnt_width(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] lo_q, lo_d;
    logic [DW-1:0] dsr_q, dsr_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rmd_q, rmd_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;

    logic [DW-1:0] step_rem;
    logic          step_q;

    unsigned_iter_divider_16by8_div_restoring_step #(
        .DW (DW)
    ) u_step (
        .rem_i     (rem_q),
        .bit_i     (lo_q[DW-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    dsr_d = bus.divisor;
                    rem_d = bus.dividend[2*DW-1:DW];
                    lo_d  = bus.dividend[DW-1:0];
                    cnt_d = CW'(DW);
                    dz_d  = 1'b0;
                    ov_d  = 1'b0;
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        rmd_d   = '0;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else if (bus.dividend[2*DW-1:DW] >= bus.divisor) begin
                        quo_d   = '1;
                        rmd_d   = '0;
                        ov_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                // Quotient bits shift into the vacated low end of the dividend register.
                rem_d = step_rem;
                lo_d  = {lo_q[DW-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    quo_d   = {lo_q[DW-2:0], step_q};
                    rmd_d   = step_rem;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            lo_q    <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.div_zero  = dz_q;
    assign bus.overflow  = ov_q;

endmodule

// File: tb/tb_unsigned_iter_divider_16by8.sv
// Self-checking bench: directed vector table, reset-abort sequence and a random sweep.
module tb_unsigned_iter_divider_16by8;
    import unsigned_iter_divider_16by8_pkg::*;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    unsigned_iter_divider_16by8_if #(.DW(DW)) bus ();

    unsigned_iter_divider_16by8 #(
        .DW (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] dd, input logic [7:0] dv);
        exp_t m;
        m.dd = dd;
        m.dv = dv;
        m.dz = 1'b0;
        m.ov = 1'b0;
        if (dv == 8'h00) begin
            m.q = 8'hFF; m.r = 8'h00; m.dz = 1'b1; m.lat = 1;
        end else if (dd[15:8] >= dv) begin
            m.q = 8'hFF; m.r = 8'h00; m.ov = 1'b1; m.lat = 1;
        end else begin
            m.q   = 8'(dd / {8'h00, dv});
            m.r   = 8'(dd % {8'h00, dv});
            m.lat = 9;
        end
        return m;
    endfunction

    task automatic run_div(input exp_t e, input int hold, input string tag);
        exp_t g;
        int   lat;
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = e.dd;
        bus.divisor  = e.dv;
        sb.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            check({tag, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        g = sb.pop_front();
        if (!bus.out_valid) begin
            check({tag, " timeout out_valid"}, 32'(bus.out_valid), 32'd1);
            return;
        end
        check({tag, " latency"}, 32'(lat), 32'(g.lat));
        check({tag, " quotient"}, 32'(bus.quotient), 32'(g.q));
        check({tag, " remainder"}, 32'(bus.remainder), 32'(g.r));
        check({tag, " div_zero"}, 32'(bus.div_zero), 32'(g.dz));
        check({tag, " overflow"}, 32'(bus.overflow), 32'(g.ov));
        check({tag, " in_ready done"}, 32'(bus.in_ready), 32'd0);
        if (!g.dz && !g.ov) begin
            check({tag, " invariant"},
                  32'(bus.quotient) * 32'(g.dv) + 32'(bus.remainder), 32'(g.dd));
            check({tag, " rem<div"}, 32'(bus.remainder < g.dv), 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, " hold quotient"}, 32'(bus.quotient), 32'(g.q));
            check({tag, " hold remainder"}, 32'(bus.remainder), 32'(g.r));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        exp_t e;
        tbl[0] = '{16'h3039, 8'h7B, 8'h64, 8'h2D, 1'b0, 1'b0, 9, 0};
        tbl[1] = '{16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0, 1'b0, 9, 0};
        tbl[2] = '{16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1, 0};
        tbl[3] = '{16'hFF00, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 0};
        tbl[4] = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 9, 5};
        tbl[5] = '{16'hFF00, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1, 0};
        tbl[6] = '{16'h0FFF, 8'h10, 8'hFF, 8'h0F, 1'b0, 1'b0, 9, 2};
        tbl[7] = '{16'h1000, 8'h10, 8'hFF, 8'h00, 1'b0, 1'b1, 1, 3};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset quotient", 32'(bus.quotient), 32'd0);
        check("reset remainder", 32'(bus.remainder), 32'd0);
        check("reset flags", {30'd0, bus.div_zero, bus.overflow}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e.dd  = tbl[i].dd;
            e.dv  = tbl[i].dv;
            e.q   = tbl[i].q;
            e.r   = tbl[i].r;
            e.dz  = tbl[i].dz;
            e.ov  = tbl[i].ov;
            e.lat = tbl[i].lat;
            run_div(e, tbl[i].hold, $sformatf("vec%0d", i));
        end

        // Abort a division in flight with an asynchronous reset pulse at N+4.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 16'h1234;
        bus.divisor  = 8'h56;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("post-rst out_valid", 32'(bus.out_valid), 32'd0);
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
        run_div(model(16'h00FF, 8'h01), 0, "after-rst");

        for (int i = 0; i < 2000; i++) begin
            int          dv;
            logic [15:0] dd;
            dv = (i % 16 == 0) ? 0 : int'($urandom_range(1, 255));
            dd = 16'($urandom);
            if ((i % 2 == 1) && dv != 0) dd[15:8] = 8'($urandom_range(0, dv - 1));
            run_div(model(dd, 8'(dv)), i % 3, "rnd");
        end

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
